// File: rtl/booth_seq_controller.sv
// booth_seq_controller: sequential radix-2 Booth multiplier, one iteration per clock,
// valid/ready handshakes on operand intake and product delivery.
module booth_seq_controller #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_m, r_q;
    logic [WIDTH:0]     r_a, w_sum, w_msx;
    logic               r_qm1;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_out;
    logic               w_last, w_accept;

    assign w_msx    = {r_m[WIDTH-1], r_m};
    assign w_last   = r_count == CW'(1);
    assign w_accept = (r_state == IDLE) && start_valid;
    // Accumulator is one bit wider than M so that M = -2^(WIDTH-1) negates without overflow
    assign w_sum = ({r_q[0], r_qm1} == 2'b01) ? r_a + w_msx :
                   ({r_q[0], r_qm1} == 2'b10) ? r_a - w_msx : r_a;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start_valid ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_a     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_m     <= in1;
                r_q     <= in2;
                r_a     <= '0;
                r_qm1   <= 1'b0;
                r_count <= CW'(WIDTH);
            end else if (r_state == RUN) begin
                r_a     <= {w_sum[WIDTH], w_sum[WIDTH:1]};
                r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                r_qm1   <= r_q[0];
                r_count <= r_count - CW'(1);
                // Product is {A[WIDTH-1:0],Q} after the final shift
                if (w_last) r_out <= {w_sum, r_q[WIDTH-1:1]};
            end
        end
    end

    assign start_ready = r_state == IDLE;
    assign out_valid   = r_state == DONE;
    assign busy        = r_state != IDLE;
    assign out         = r_out;
endmodule
